instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 109 ++++++++++
 tb/tb_instr_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch front end: the fetch PC drives a one-word-per-cycle
// instruction memory, and responses are queued in a 2-entry {pc, instr} FIFO
// for decode. A redirect flushes the queue and restarts fetch at the target.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // ent0 is always the head, so the decode outputs come straight from flops
  ent_t        ent0, ent1;
  logic [1:0]  cnt;
  logic [31:0] fpc;
  logic        inflight;     // a request went out last cycle; its data is on imem_rdata_i now
  logic [31:0] inflight_pc;
  logic        rd, wr;
  logic [1:0]  occ;
  ent_t        nent;
  logic        unused_lo;

  assign valid_o     = (cnt != 2'd0);
  assign instr_o     = ent0.instr;
  assign pc_o        = ent0.pc;
  assign opcode_o    = ent0.instr[6:0];
  assign imem_addr_o = fpc;

  // redirect beats both the retire and the response write in the same cycle
  assign rd   = valid_o & ready_i & ~redirect_i;
  assign wr   = inflight & ~redirect_i;
  assign nent = {inflight_pc, imem_rdata_i};

  // Occupancy at the end of this cycle (current count, plus the response
  // landing now, minus a retire now). Issuing only while that is below 2
  // guarantees the slot for our response next cycle, and still lets a
  // draining consumer see one instruction per cycle.
  assign occ        = cnt + {1'b0, wr} - {1'b0, rd};
  assign imem_req_o = rst_n & ~redirect_i & (occ < 2'd2);

  // target low bits are forced to zero, so they are never consumed
  assign unused_lo = ^redirect_pc_i[1:0];

  // Fetch PC and in-flight tracking. Clearing inflight on a redirect (or
  // reset) is what marks the outstanding response for discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc         <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
    end else if (redirect_i) begin
      fpc      <= {redirect_pc_i[31:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req_o;
      if (imem_req_o) begin
        inflight_pc <= fpc;
        fpc         <= fpc + 32'd4;
      end
    end
  end

  // 2-entry queue with a fixed head slot: a retire shifts ent1 down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else if (redirect_i) begin
      cnt <= 2'd0;
    end else begin
      case ({rd, wr})
        2'b11: begin
          if (cnt == 2'd2) begin
            ent0 <= ent1;
            ent1 <= nent;
          end else begin
            ent0 <= nent;
          end
        end
        2'b10: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd0) ent0 <= nent;
          else             ent1 <= nent;
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a queue-level model of the fetch stream checked every
// cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ready = 1'b1;
  logic [31:0] rdata = 32'h0;
  logic [31:0] key = 32'h0;
  logic        req, valid;
  logic [31:0] addr, instr, pc;
  logic [6:0]  opcode;

  // second instance for the address-wrap case
  logic        redirect1 = 1'b0;
  logic [31:0] redirect_pc1 = 32'h0;
  logic        ready1 = 1'b1;
  logic [31:0] rdata1 = 32'h0;
  logic        req1, valid1;
  logic [31:0] addr1, instr1, pc1;
  logic [6:0]  opcode1;

  int tests = 0;
  int fails = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) u0 (
    .clk(clk), .rst_n(rst_n), .imem_req_o(req), .imem_addr_o(addr),
    .imem_rdata_i(rdata), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .valid_o(valid), .ready_i(ready), .instr_o(instr), .pc_o(pc), .opcode_o(opcode));

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u1 (
    .clk(clk), .rst_n(rst_n), .imem_req_o(req1), .imem_addr_o(addr1),
    .imem_rdata_i(rdata1), .redirect_i(redirect1), .redirect_pc_i(redirect_pc1),
    .valid_o(valid1), .ready_i(ready1), .instr_o(instr1), .pc_o(pc1), .opcode_o(opcode1));

  // instruction memories: word content is address ^ key; garbage when not requested
  always @(posedge clk) begin
    rdata  <= req  ? (addr ^ key) : 32'hDEAD_BEEF;
    rdata1 <= req1 ? addr1 : 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model: stream of pcs waiting for decode ----------------
  logic [31:0] mq[$];
  logic [31:0] m_fpc = 32'h0;
  logic [31:0] m_inf_pc = 32'h0;
  bit          m_inf = 1'b0;

  function automatic bit m_take();
    return (mq.size() > 0) && (ready === 1'b1);
  endfunction

  // fetch allowed when the queue plus the arriving word, less a retire, leaves room
  function automatic bit m_req();
    int o;
    o = mq.size() + int'(m_inf) - int'(m_take());
    return (rst_n === 1'b1) && (redirect !== 1'b1) && (o < 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit r, t;
    if (!rst_n) begin
      mq.delete();
      m_fpc = 32'h0;
      m_inf = 1'b0;
    end else if (redirect) begin
      mq.delete();
      m_inf = 1'b0;
      m_fpc = {redirect_pc[31:2], 2'b00};
    end else begin
      r = m_req();
      t = m_take();
      if (t) void'(mq.pop_front());
      if (m_inf) mq.push_back(m_inf_pc);
      m_inf = r;
      if (r) begin
        m_inf_pc = m_fpc;
        m_fpc    = m_fpc + 32'd4;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("m_valid", {31'b0, valid}, {31'b0, mq.size() > 0});
      if (mq.size() > 0) begin
        chk("m_pc", pc, mq[0]);
        chk("m_instr", instr, mq[0] ^ key);
        chk("m_opcode", {25'b0, opcode}, {25'b0, mq[0][6:0] ^ key[6:0]});
      end
      chk("m_req", {31'b0, req}, {31'b0, m_req()});
      if (m_req()) chk("m_addr", addr, m_fpc);
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opcode", {25'b0, opcode}, 32'h0);
    chk("rst_req", {31'b0, req}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_addr_wrap", addr1, 32'hFFFF_FFF8);

    // fill and stream: addr-as-data, one per cycle from cycle 3
    rst_n = 1'b1;
    tick(); tick();
    chk("fill_valid", {31'b0, valid}, 32'h1);
    chk("fill_pc0", pc, 32'h0);
    chk("fill_instr0", instr, 32'h0);
    chk("wrap_pc0", pc1, 32'hFFFF_FFF8);
    tick();
    chk("fill_pc4", pc, 32'h4);
    chk("fill_opc4", {25'b0, opcode}, 32'h4);
    chk("wrap_pc1", pc1, 32'hFFFF_FFFC);
    tick();
    chk("fill_pc8", pc, 32'h8);
    chk("wrap_pc2", pc1, 32'h0);
    chk("wrap_instr2", instr1, 32'h0);
    chk("wrap_valid2", {31'b0, valid1}, 32'h1);
    chk("wrap_opc2", {25'b0, opcode1}, 32'h0);
    repeat (4) tick();

    // stall after fill
    rst_n = 1'b0; key = 32'h1234_5000; ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("stall_pc_first", pc, 32'h0);
    repeat (5) tick();
    chk("stall_valid", {31'b0, valid}, 32'h1);
    chk("stall_pc", pc, 32'h0);
    chk("stall_instr", instr, 32'h1234_5000);
    chk("stall_req", {31'b0, req}, 32'h0);
    ready = 1'b1;
    #1;
    chk("drain_pc0", pc, 32'h0);
    tick();
    chk("drain_pc4", pc, 32'h4);
    tick();
    chk("drain_pc8", pc, 32'h8);
    chk("drain_instr8", instr, 32'h1234_5008);
    repeat (2) tick();

    // redirect with queue occupied and a response in flight
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    chk("redir_req_n", {31'b0, req}, 32'h0);
    tick();
    redirect = 1'b0;
    #1;
    chk("redir_valid_n1", {31'b0, valid}, 32'h0);
    chk("redir_req_n1", {31'b0, req}, 32'h1);
    chk("redir_addr_n1", addr, 32'h0000_0100);
    tick();
    chk("redir_valid_n2", {31'b0, valid}, 32'h0);
    tick();
    chk("redir_valid_n3", {31'b0, valid}, 32'h1);
    chk("redir_pc_n3", pc, 32'h0000_0100);
    chk("redir_instr_n3", instr, 32'h1234_5100);
    tick();
    chk("redir_pc_n4", pc, 32'h0000_0104);

    // back-to-back redirects: only the last target is fetched
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    #1;
    chk("b2b_valid", {31'b0, valid}, 32'h0);
    chk("b2b_addr", addr, 32'h80);
    chk("b2b_req", {31'b0, req}, 32'h1);
    tick();
    chk("b2b_valid2", {31'b0, valid}, 32'h0);
    tick();
    chk("b2b_valid3", {31'b0, valid}, 32'h1);
    chk("b2b_pc3", pc, 32'h80);
    tick();
    chk("b2b_pc4", pc, 32'h84);

    // asynchronous reset pulse with the queue full
    ready = 1'b0;
    repeat (3) tick();
    chk("full_pc", pc, 32'h84);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, valid}, 32'h0);
    chk("async_pc", pc, 32'h0);
    chk("async_req", {31'b0, req}, 32'h0);
    #2 rst_n = 1'b1;
    ready = 1'b1;
    tick(); tick();
    chk("restart_valid", {31'b0, valid}, 32'h1);
    chk("restart_pc", pc, 32'h0);
    chk("restart_instr", instr, 32'h1234_5000);
    tick();
    chk("restart_pc4", pc, 32'h4);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
